// File: rtl/uart_tx_datapath.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_datapath
// Description : UART transmit datapath. Captures a parallel word with its
//               parity, serializes it LSB-first under FSM control and drives
//               the registered serial line through a frame-field mux.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_TYP,
    input  logic             Busy,
    input  logic             ser_en,
    input  logic [1:0]       mux_sel,
    output logic             ser_done,
    output logic             TX_OUT,
    output logic             par_bit
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_SEL_START  = 2'b00;
    localparam logic [1:0] c_SEL_IDLE   = 2'b01;
    localparam logic [1:0] c_SEL_DATA   = 2'b10;
    localparam logic [1:0] c_SEL_PARITY = 2'b11;

    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   shift_reg_q, shift_reg_d;
    logic [c_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic               par_bit_q,   par_bit_d;
    logic               tx_out_q,    tx_out_d;

    logic w_load;
    logic w_shift;
    logic w_ser_out;
    logic w_mux;

    // A word offered while a frame is in flight is dropped, not queued.
    assign w_load    = DATA_VALID & ~Busy;
    assign w_shift   = ser_en & (mux_sel == c_SEL_DATA) & ~w_load;
    assign w_ser_out = shift_reg_q[0];

    always_comb begin
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        par_bit_d   = par_bit_q;
        if (w_load) begin
            shift_reg_d = P_DATA;
            bit_cnt_d   = '0;
            par_bit_d   = PAR_TYP ? ~^P_DATA : ^P_DATA;
        end else if (w_shift) begin
            shift_reg_d = {1'b0, shift_reg_q[WIDTH-1:1]};
            bit_cnt_d   = (bit_cnt_q == c_LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    always_comb begin
        w_mux = 1'b1;
        case (mux_sel)
            c_SEL_START:  w_mux = 1'b0;
            c_SEL_IDLE:   w_mux = 1'b1;
            c_SEL_DATA:   w_mux = w_ser_out;
            c_SEL_PARITY: w_mux = par_bit_q;
            default:      w_mux = 1'b1;
        endcase
    end

    assign tx_out_d = w_mux;

    // Line resets high so an aborted frame falls straight back to idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            par_bit_q   <= 1'b0;
            tx_out_q    <= 1'b1;
        end else begin
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
            par_bit_q   <= par_bit_d;
            tx_out_q    <= tx_out_d;
        end
    end

    // Not gated by ser_en so the FSM may release it in the final data cycle.
    assign ser_done = (mux_sel == c_SEL_DATA) && (bit_cnt_q == c_LAST_BIT);
    assign TX_OUT   = tx_out_q;
    assign par_bit  = par_bit_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_datapath
// Description : Directed scoreboard bench for uart_tx_datapath (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_datapath;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_TYP;
    logic             Busy;
    logic             ser_en;
    logic [1:0]       mux_sel;
    logic             ser_done;
    logic             TX_OUT;
    logic             par_bit;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];

    uart_tx_datapath #(.WIDTH(WIDTH)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_TYP    (PAR_TYP),
        .Busy       (Busy),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .ser_done   (ser_done),
        .TX_OUT     (TX_OUT),
        .par_bit    (par_bit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check ser_done before the edge, then compare
    // the registered line against the oldest scoreboard entry.
    task automatic step(input logic busy, input logic en, input logic [1:0] ms,
                        input logic dv, input logic [7:0] pd, input logic pt,
                        input logic exp_done);
        Busy = busy; ser_en = en; mux_sel = ms;
        DATA_VALID = dv; P_DATA = pd; PAR_TYP = pt;
        #1;
        chk("ser_done", ser_done, exp_done);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL tx_scoreboard observed=empty expected=entry");
        end else begin
            chk("tx_out", TX_OUT, exp_q.pop_front());
        end
        DATA_VALID = 1'b0;
    endtask

    // Load slot (also the previous frame's stop bit), start, data, parity.
    task automatic frame(input logic [7:0] d, input logic pt, input logic use_par,
                         input int ff_idx, input logic drop_last);
        logic p;
        p = pt ? ~^d : ^d;
        exp_q.push_back(1'b1);
        step(1'b0, 1'b0, 2'b01, 1'b1, d, pt, 1'b0);
        chk("par_bit_load", par_bit, p);
        exp_q.push_back(1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            exp_q.push_back(d[i]);
            step(1'b1, !(drop_last && i == WIDTH - 1), 2'b10, (i == ff_idx),
                 8'hFF, ~pt, (i == WIDTH - 1));
        end
        if (drop_last) begin
            exp_q.push_back(d[WIDTH-1]);
            step(1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        if (use_par) begin
            exp_q.push_back(p);
            step(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        chk("par_bit_hold", par_bit, p);
    endtask

    task automatic idle_step();
        exp_q.push_back(1'b1);
        step(1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; Busy = 1'b0; ser_en = 1'b0; mux_sel = 2'b01;
        DATA_VALID = 1'b0; P_DATA = '0; PAR_TYP = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", TX_OUT, 1'b1);
        chk("rst_par", par_bit, 1'b0);
        chk("rst_done", ser_done, 1'b0);
        rst = 1'b0;
        idle_step();

        // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0 then stop 1
        frame(8'hA5, 1'b0, 1'b1, -1, 1'b0);
        idle_step();
        frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
        frame(8'h00, 1'b0, 1'b1, -1, 1'b0);
        frame(8'h00, 1'b1, 1'b1, -1, 1'b0);
        idle_step();

        // ser_done with ser_en released in the last data cycle
        frame(8'hC3, 1'b0, 1'b1, -1, 1'b1);
        idle_step();

        // Ignored DATA_VALID while busy
        frame(8'h3C, 1'b0, 1'b1, 2, 1'b0);
        idle_step();

        // Back-to-back, no parity: single stop bit between frames
        frame(8'h01, 1'b0, 1'b0, -1, 1'b0);
        frame(8'h80, 1'b0, 1'b0, -1, 1'b0);
        idle_step();

        // Asynchronous reset in the final data cycle of an odd-parity 0x00 frame
        exp_q.push_back(1'b1);
        step(1'b0, 1'b0, 2'b01, 1'b1, 8'h00, 1'b1, 1'b0);
        exp_q.push_back(1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) begin
            exp_q.push_back(1'b0);
            step(1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        Busy = 1'b1; ser_en = 1'b1; mux_sel = 2'b10;
        #1;
        chk("pre_rst_done", ser_done, 1'b1);
        chk("pre_rst_par", par_bit, 1'b1);
        chk("pre_rst_tx", TX_OUT, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_tx", TX_OUT, 1'b1);
        chk("async_rst_par", par_bit, 1'b0);
        chk("async_rst_done", ser_done, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_rst_tx", TX_OUT, 1'b1);
        mux_sel = 2'b01; Busy = 1'b0; ser_en = 1'b0;
        rst = 1'b0;
        idle_step();
        frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
        idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_datapath.md
Name: uart_tx_datapath

Overview:
- Transmit datapath paired with the UART TX control FSM.
- Captures the parallel byte and computes its parity bit.
- Shifts data out LSB-first under FSM control and returns ser_done at the last data bit.
- Drives the registered serial line TX_OUT through a 4-way frame-field mux selected by the FSM's mux_sel.

Parameters:
WIDTH, 8, number of data bits per frame (valid range 2..16)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  reset; asynchronous, active-high
P_DATA  input  WIDTH  parallel data word to transmit
DATA_VALID  input  1  single-cycle strobe: P_DATA valid
PAR_TYP  input  1  parity type: 0 = even, 1 = odd
Busy  input  1  from FSM: frame in progress
ser_en  input  1  from FSM: shift enable
mux_sel  input  2  from FSM: 00 start, 01 idle/stop, 10 data, 11 parity
ser_done  output  1  combinational: last data bit is on the serializer output
TX_OUT  output  1  registered serial line
par_bit  output  1  registered parity of the captured word

Behaviour:
- Reset (RST=1, asynchronous): TX_OUT=1; par_bit=0; shift_reg=0; bit_cnt=0; ser_done evaluates to 0. Reset mid-frame aborts immediately, and the line returns to idle-high with no glitch to 0.
- Load condition: DATA_VALID=1 && Busy=0 at a rising edge. On load:
  - shift_reg <= P_DATA; bit_cnt <= 0.
  - par_bit <= ^P_DATA when PAR_TYP=0, else ~^P_DATA. PAR_TYP is sampled only at load.
- DATA_VALID while Busy=1 is ignored. shift_reg, bit_cnt and par_bit must not change.
- Load has priority over shift in the same cycle. In a legal flow they never coincide.
- ser_out = shift_reg[0] (internal, combinational).
- Shift condition: ser_en=1 && mux_sel=10 && no load. Action: shift_reg >>= 1 (MSB filled 0), bit_cnt += 1.
  - When bit_cnt=WIDTH-1 and a shift occurs, bit_cnt wraps to 0.
  - ser_en=1 with any other mux_sel causes no shift.
- ser_done = (mux_sel==10) && (bit_cnt==WIDTH-1). It is independent of ser_en, so the FSM may drop ser_en in the last data cycle.
- Mux (combinational): 00 -> 0; 01 -> 1; 10 -> ser_out; 11 -> par_bit.
- TX_OUT <= mux result every cycle. The line lags mux_sel by exactly 1 clock.
- Frame field durations: start 1 cycle; data WIDTH cycles; parity 1 cycle (when the FSM selects it); stop/idle = every cycle with mux_sel=01.
- Back-to-back frames: a new load is accepted on the first cycle Busy=0. The stop bit is still emitted because mux_sel=01 during that cycle.
- Illegal mux_sel sequencing is not detected; the block follows mux_sel literally.

Test Plan:
1. Reset: assert RST for 3 cycles mid-traffic -> TX_OUT=1, par_bit=0, ser_done=0 asynchronously, before the next edge.
2. P_DATA=0xA5, PAR_TYP=0, FSM drives start/data/parity/stop -> TX_OUT from the cycle after start select: 0,1,0,1,0,0,1,0,1,0,1. Field order: start, data LSB-first, parity=0, stop.
3. Same word with PAR_TYP=1 -> par_bit=1; parity slot on TX_OUT = 1. P_DATA=0x00, PAR_TYP=0 -> par_bit=0. P_DATA=0x00, PAR_TYP=1 -> par_bit=1.
4. ser_done timing: WIDTH=8, mux_sel held at 10 with ser_en=1 -> ser_done high only in the 8th data cycle (bit_cnt=7). Also with ser_en dropped in that cycle -> ser_done still 1, bit_cnt stays 7.
5. DATA_VALID pulse with P_DATA=0xFF while Busy=1 during a 0x3C frame -> transmitted data bits remain 0,0,1,1,1,1,0,0; par_bit unchanged.
6. Back-to-back 0x01 then 0x80, no parity -> each frame ends with exactly one stop bit; second frame data bits 0,0,0,0,0,0,0,1.
